// File: rtl/uart_frame_packer.sv
// Purpose : snapshots NUM_CH width/period measurements on a frame trigger and
//           serialises header, per-channel records and an optional checksum
//           LSB-first into bytes for the UART TX FIFO.
// Latency : first header byte strobes two cycles after the trigger cycle,
//           then one byte per cycle while the FIFO has room.
// Backpressure: while tx_fifo_usedw >= FIFO_THR nothing is written and the
//           whole frame state holds; triggers arriving while busy are dropped
//           and counted as overruns.
//
// Ports:
//   clk, rst (async, active-low)   clock / reset
//   ena, frame_start, frame_cnt    trigger enable, trigger pulse, sequence number
//   ch_mask, width_bus, period_bus channel enables and packed measurements
//   tx_fifo_wen/wdata/usedw        FIFO write strobe, data and fill level
//   busy, overrun, overrun_cnt     status and dropped-trigger accounting

module uart_frame_packer #(
   parameter int          NUM_CH   = 12,
   parameter int          MEAS_W   = 32,
   parameter logic [31:0] HEAD     = 32'h7FFF7FFF,
   parameter int          FIFO_AW  = 12,
   parameter int          FIFO_THR = 2000,
   parameter bit          CKSUM_EN = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ena,
   input  logic                     frame_start,
   input  logic [15:0]              frame_cnt,
   input  logic [NUM_CH-1:0]        ch_mask,
   input  logic [NUM_CH*MEAS_W-1:0] width_bus,
   input  logic [NUM_CH*MEAS_W-1:0] period_bus,
   output logic                     tx_fifo_wen,
   output logic [7:0]               tx_fifo_wdata,
   input  logic [FIFO_AW-1:0]       tx_fifo_usedw,
   output logic                     busy,
   output logic                     overrun,
   output logic [7:0]               overrun_cnt
);

   localparam int MB   = MEAS_W / 8;
   localparam int CH_W = $clog2(NUM_CH + 1);
   localparam int BI_W = 4;   // byte index within header (0..6) or record (0..2*MB)

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_CH, S_SUM} state_t;

   state_t                     r_state;
   logic [NUM_CH*MEAS_W-1:0]   r_wsnap;
   logic [NUM_CH*MEAS_W-1:0]   r_psnap;
   logic [NUM_CH-1:0]          r_mask;
   logic [15:0]                r_fcnt;
   logic [7:0]                 r_cksum;
   logic [BI_W-1:0]            r_bidx;
   logic [CH_W-1:0]            r_ch;
   logic                       r_wen;
   logic [7:0]                 r_wdata;
   logic                       r_busy;
   logic                       r_ovr;
   logic [7:0]                 r_ocnt;

   logic                       w_space;
   logic [7:0]                 w_nen;
   logic                       w_cur_en;
   logic                       w_last_ch;
   logic                       w_rec_last;
   logic                       w_adv;
   logic [MEAS_W-1:0]          w_wfield;
   logic [MEAS_W-1:0]          w_pfield;
   logic [MEAS_W-1:0]          w_fld;
   logic [BI_W-1:0]            w_off;
   logic [7:0]                 w_fbyte;
   logic [7:0]                 w_byte;

   always_comb begin
      w_space    = tx_fifo_usedw < FIFO_AW'(FIFO_THR);
      w_nen      = 8'($countones(r_mask));
      w_cur_en   = 1'(r_mask >> r_ch);
      w_last_ch  = (r_ch == CH_W'(NUM_CH - 1));
      w_rec_last = (r_bidx == BI_W'(2 * MB));
      // A channel is finished either because it is masked off (skipped in
      // one cycle) or because its last record byte goes out this cycle.
      w_adv      = (r_state == S_CH) && (!w_cur_en || w_rec_last);

      w_wfield   = MEAS_W'(r_wsnap >> (32'(r_ch) * MEAS_W));
      w_pfield   = MEAS_W'(r_psnap >> (32'(r_ch) * MEAS_W));

      // Record layout: index byte, MB width bytes, MB period bytes.
      if (r_bidx <= BI_W'(MB)) begin
         w_fld = w_wfield;
         w_off = r_bidx - BI_W'(1);
      end else begin
         w_fld = w_pfield;
         w_off = r_bidx - BI_W'(MB) - BI_W'(1);
      end
      w_fbyte = 8'(w_fld >> (32'(w_off) * 8));

      w_byte = 8'h00;
      case (r_state)
         S_HDR: begin
            case (r_bidx)
               4'd0:    w_byte = HEAD[7:0];
               4'd1:    w_byte = HEAD[15:8];
               4'd2:    w_byte = HEAD[23:16];
               4'd3:    w_byte = HEAD[31:24];
               4'd4:    w_byte = r_fcnt[7:0];
               4'd5:    w_byte = r_fcnt[15:8];
               default: w_byte = w_nen;
            endcase
         end
         S_CH:    w_byte = (r_bidx == '0) ? 8'(r_ch) : w_fbyte;
         S_SUM:   w_byte = r_cksum;
         default: w_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_wsnap <= '0;
         r_psnap <= '0;
         r_mask  <= '0;
         r_fcnt  <= '0;
         r_cksum <= '0;
         r_bidx  <= '0;
         r_ch    <= '0;
         r_wen   <= 1'b0;
         r_wdata <= '0;
         r_busy  <= 1'b0;
         r_ovr   <= 1'b0;
         r_ocnt  <= '0;
      end else begin
         r_wen <= 1'b0;
         r_ovr <= 1'b0;
         // busy trails the state by one cycle so it stays high while the
         // final byte's strobe is on the bus; a trigger in that cycle drops.
         r_busy <= (r_state != S_IDLE);

         if (frame_start && ena) begin
            if (r_busy) begin
               r_ovr <= 1'b1;
               if (r_ocnt != 8'hFF) begin
                  r_ocnt <= r_ocnt + 8'd1;
               end
            end else if (r_state == S_IDLE) begin
               r_wsnap <= width_bus;
               r_psnap <= period_bus;
               r_mask  <= ch_mask;
               r_fcnt  <= frame_cnt;
               r_cksum <= '0;
               r_bidx  <= '0;
               r_ch    <= '0;
               r_state <= S_HDR;
               r_busy  <= 1'b1;
            end
         end

         if (w_space) begin
            case (r_state)
               S_HDR: begin
                  r_wen   <= 1'b1;
                  r_wdata <= w_byte;
                  // The four fixed header bytes are excluded from the sum.
                  if (r_bidx >= BI_W'(4)) begin
                     r_cksum <= r_cksum + w_byte;
                  end
                  if (r_bidx == BI_W'(6)) begin
                     r_bidx  <= '0;
                     r_ch    <= '0;
                     r_state <= S_CH;
                  end else begin
                     r_bidx <= r_bidx + BI_W'(1);
                  end
               end
               S_CH: begin
                  if (w_cur_en) begin
                     r_wen   <= 1'b1;
                     r_wdata <= w_byte;
                     r_cksum <= r_cksum + w_byte;
                     r_bidx  <= w_rec_last ? '0 : r_bidx + BI_W'(1);
                  end
                  if (w_adv) begin
                     if (w_last_ch) begin
                        r_state <= CKSUM_EN ? S_SUM : S_IDLE;
                     end else begin
                        r_ch <= r_ch + CH_W'(1);
                     end
                  end
               end
               S_SUM: begin
                  r_wen   <= 1'b1;
                  r_wdata <= r_cksum;
                  r_state <= S_IDLE;
               end
               default: ;
            endcase
         end
      end
   end

   assign tx_fifo_wen   = r_wen;
   assign tx_fifo_wdata = r_wdata;
   assign busy          = r_busy;
   assign overrun       = r_ovr;
   assign overrun_cnt   = r_ocnt;

endmodule

// File: tb/tb_uart_frame_packer.sv
// Purpose : exercises uart_frame_packer in its default 12x32 configuration and
//           a 4x16 no-checksum configuration against a byte-stream model.
// Latency : first header byte expected two cycles after the trigger cycle.
// Backpressure: usedw stall, dropped triggers and mid-frame reset scenarios.

module tb_uart_frame_packer;

   typedef logic [7:0] bq_t[$];

   logic         clk = 1'b0;
   logic         rst;
   logic         ena;
   logic         frame_start;
   logic [15:0]  frame_cnt;
   logic [11:0]  ch_mask;
   logic [383:0] width_bus;
   logic [383:0] period_bus;
   logic         tx_fifo_wen;
   logic [7:0]   tx_fifo_wdata;
   logic [11:0]  tx_fifo_usedw;
   logic         busy;
   logic         overrun;
   logic [7:0]   overrun_cnt;

   logic         fs2;
   logic [3:0]   mask2;
   logic [63:0]  wb2;
   logic [63:0]  pb2;
   logic         wen2;
   logic [7:0]   wd2;
   logic [11:0]  usedw2;
   logic         busy2;
   logic         ovr2;
   logic [7:0]   ocnt2;

   logic [31:0]  wv[12];
   logic [31:0]  pv[12];
   bq_t          q;
   bq_t          q2;
   int           ovr_pulses = 0;
   int           errors = 0;
   int           checks = 0;

   always #5 clk = ~clk;

   uart_frame_packer dut (
      .clk(clk), .rst(rst), .ena(ena), .frame_start(frame_start),
      .frame_cnt(frame_cnt), .ch_mask(ch_mask), .width_bus(width_bus),
      .period_bus(period_bus), .tx_fifo_wen(tx_fifo_wen),
      .tx_fifo_wdata(tx_fifo_wdata), .tx_fifo_usedw(tx_fifo_usedw),
      .busy(busy), .overrun(overrun), .overrun_cnt(overrun_cnt)
   );

   uart_frame_packer #(.NUM_CH(4), .MEAS_W(16), .CKSUM_EN(1'b0)) dut2 (
      .clk(clk), .rst(rst), .ena(ena), .frame_start(fs2),
      .frame_cnt(frame_cnt), .ch_mask(mask2), .width_bus(wb2),
      .period_bus(pb2), .tx_fifo_wen(wen2), .tx_fifo_wdata(wd2),
      .tx_fifo_usedw(usedw2), .busy(busy2), .overrun(ovr2),
      .overrun_cnt(ocnt2)
   );

   // Byte capture, sampled mid-cycle.
   always @(negedge clk) begin
      if (tx_fifo_wen) q.push_back(tx_fifo_wdata);
      if (wen2) q2.push_back(wd2);
      if (overrun) ovr_pulses++;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference frame built directly from the frame layout rules.
   function automatic bq_t model(input int nch, input int mb, input bit ck,
                                 input logic [15:0] fc, input logic [31:0] mask,
                                 input logic [31:0] w[12], input logic [31:0] p[12]);
      bq_t         r;
      logic [31:0] head = 32'h7FFF7FFF;
      logic [7:0]  s = 8'h00;
      int          n = 0;
      for (int i = 0; i < 4; i++) r.push_back(head[8*i +: 8]);
      r.push_back(fc[7:0]);
      r.push_back(fc[15:8]);
      for (int c = 0; c < nch; c++) if (mask[c]) n++;
      r.push_back(8'(n));
      for (int c = 0; c < nch; c++) begin
         if (mask[c]) begin
            r.push_back(8'(c));
            for (int b = 0; b < mb; b++) r.push_back(w[c][8*b +: 8]);
            for (int b = 0; b < mb; b++) r.push_back(p[c][8*b +: 8]);
         end
      end
      if (ck) begin
         for (int i = 4; i < r.size(); i++) s = s + r[i];
         r.push_back(s);
      end
      return r;
   endfunction

   task automatic randomize_data();
      for (int c = 0; c < 12; c++) begin
         wv[c] = $urandom;
         pv[c] = $urandom;
      end
   endtask

   task automatic load_bus();
      for (int c = 0; c < 12; c++) begin
         width_bus[c*32 +: 32]  = wv[c];
         period_bus[c*32 +: 32] = pv[c];
      end
      for (int c = 0; c < 4; c++) begin
         wb2[c*16 +: 16] = wv[c][15:0];
         pb2[c*16 +: 16] = pv[c][15:0];
      end
   endtask

   task automatic pulse_start(input bit second);
      @(posedge clk);
      #1;
      if (second) fs2 = 1'b1; else frame_start = 1'b1;
      @(posedge clk);
      #1;
      fs2 = 1'b0;
      frame_start = 1'b0;
   endtask

   // Waits (bounded) for the first mid-cycle sample with busy low.
   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (tx_fifo_wen !== 1'b0) begin errors++; $display("FAIL rst_wen: got %b want 0", tx_fifo_wen); end
      checks++; if (tx_fifo_wdata !== 8'h00) begin errors++; $display("FAIL rst_wdata: got %h want 00", tx_fifo_wdata); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", overrun); end
      checks++; if (overrun_cnt !== 8'h00) begin errors++; $display("FAIL rst_ocnt: got %h want 00", overrun_cnt); end
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_all_channels();
      bq_t e;
      bq_t h;
      bq_t r3;
      bit  ok;
      int  bad = 0;
      randomize_data();
      wv[3] = 32'h00A1B2C3;
      pv[3] = 32'h11223344;
      frame_cnt = 16'h1234;
      ch_mask = 12'hFFF;
      load_bus();
      q.delete();
      e = model(12, 4, 1'b1, 16'h1234, 32'hFFF, wv, pv);
      pulse_start(1'b0);
      @(negedge clk);
      checks++; if (tx_fifo_wen !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL lat_early: got wen=%b busy=%b want wen=0 busy=1", tx_fifo_wen, busy); end
      @(negedge clk);
      checks++; if (tx_fifo_wen !== 1'b1 || tx_fifo_wdata !== 8'hFF) begin errors++; $display("FAIL lat_first: got wen=%b data=%h want wen=1 data=FF", tx_fifo_wen, tx_fifo_wdata); end
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL all_done: got timeout want frame end"); end
      checks++; if (q.size() != 116) begin errors++; $display("FAIL all_len: got %0d want 116", q.size()); end
      for (int i = 0; i < e.size(); i++) if (q[i] !== e[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL all_bytes: got %0d mismatching bytes want 0", bad); end
      h = {8'hFF, 8'h7F, 8'hFF, 8'h7F, 8'h34, 8'h12, 8'h0C};
      bad = 0;
      for (int i = 0; i < 7; i++) if (q[i] !== h[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL all_hdr: got %0d mismatching header bytes want 0", bad); end
      r3 = {8'h03, 8'hC3, 8'hB2, 8'hA1, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
      bad = 0;
      for (int i = 0; i < 9; i++) if (q[34+i] !== r3[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL all_ch3: got %0d mismatching record bytes want 0", bad); end
   endtask

   task automatic test_mask_and_ena();
      bq_t e;
      bit  ok;
      int  bad = 0;
      int  sz;
      randomize_data();
      frame_cnt = 16'($urandom);
      ch_mask = 12'h005;
      load_bus();
      q.delete();
      ovr_pulses = 0;
      e = model(12, 4, 1'b1, frame_cnt, 32'h005, wv, pv);
      pulse_start(1'b0);
      ena = 1'b0;
      repeat (5) @(posedge clk);
      pulse_start(1'b0);
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL mask_done: got timeout want frame end"); end
      checks++; if (q.size() != 26) begin errors++; $display("FAIL mask_len: got %0d want 26", q.size()); end
      checks++; if (q[6] !== 8'h02 || q[7] !== 8'h00 || q[16] !== 8'h02) begin errors++; $display("FAIL mask_idx: got nen=%h r0=%h r1=%h want 02 00 02", q[6], q[7], q[16]); end
      for (int i = 0; i < e.size(); i++) if (q[i] !== e[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL mask_bytes: got %0d mismatching bytes want 0", bad); end
      sz = q.size();
      pulse_start(1'b0);
      repeat (5) @(negedge clk);
      checks++; if (busy !== 1'b0 || q.size() != sz || ovr_pulses != 0) begin errors++; $display("FAIL ena_off: got busy=%b bytes=%0d ovr=%0d want 0 %0d 0", busy, q.size(), ovr_pulses, sz); end
      ena = 1'b1;
   endtask

   task automatic test_stall();
      bq_t e;
      bit  ok;
      int  bad = 0;
      int  stall_wen = 0;
      randomize_data();
      frame_cnt = 16'($urandom);
      ch_mask = 12'($urandom);
      load_bus();
      q.delete();
      e = model(12, 4, 1'b1, frame_cnt, {20'h0, ch_mask}, wv, pv);
      pulse_start(1'b0);
      for (int i = 0; i < 50 && q.size() < 3; i++) @(posedge clk);
      #1 tx_fifo_usedw = 12'd2000;
      @(posedge clk);
      repeat (20) begin
         @(negedge clk);
         if (tx_fifo_wen) stall_wen++;
      end
      checks++; if (stall_wen != 0) begin errors++; $display("FAIL stall_wen: got %0d strobes want 0", stall_wen); end
      checks++; if (q.size() != 4) begin errors++; $display("FAIL stall_held: got %0d bytes want 4", q.size()); end
      @(posedge clk);
      #1 tx_fifo_usedw = 12'($urandom_range(0, 1999));
      wait_done(ok);
      tx_fifo_usedw = 12'd0;
      checks++; if (!ok || q.size() != e.size()) begin errors++; $display("FAIL stall_len: got %0d want %0d", q.size(), e.size()); end
      for (int i = 0; i < e.size(); i++) if (q[i] !== e[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL stall_bytes: got %0d mismatching bytes want 0", bad); end
   endtask

   task automatic test_overrun();
      bq_t e;
      bit  ok;
      int  bad = 0;
      randomize_data();
      frame_cnt = 16'($urandom);
      ch_mask = 12'hFFF;
      load_bus();
      q.delete();
      ovr_pulses = 0;
      e = model(12, 4, 1'b1, frame_cnt, 32'hFFF, wv, pv);
      pulse_start(1'b0);
      randomize_data();
      load_bus();
      frame_cnt = 16'($urandom);
      repeat (28) @(posedge clk);
      pulse_start(1'b0);
      wait_done(ok);
      checks++; if (ovr_pulses != 1 || overrun_cnt !== 8'd1) begin errors++; $display("FAIL ovr_once: got pulses=%0d cnt=%0d want 1 1", ovr_pulses, overrun_cnt); end
      for (int i = 0; i < e.size(); i++) if (q[i] !== e[i]) bad++;
      checks++; if (!ok || q.size() != e.size() || bad != 0) begin errors++; $display("FAIL ovr_frame: got len=%0d bad=%0d want len=%0d bad=0", q.size(), bad, e.size()); end
      // Trigger held high: frames go back to back and every busy cycle drops.
      randomize_data();
      ch_mask = 12'h001;
      load_bus();
      e = model(12, 4, 1'b1, frame_cnt, 32'h001, wv, pv);
      q.delete();
      ovr_pulses = 0;
      @(posedge clk);
      #1 frame_start = 1'b1;
      repeat (400) @(posedge clk);
      #1 frame_start = 1'b0;
      wait_done(ok);
      checks++; if (overrun_cnt !== 8'd255 || ovr_pulses < 255) begin errors++; $display("FAIL ovr_sat: got cnt=%0d pulses=%0d want 255 >=255", overrun_cnt, ovr_pulses); end
      bad = 0;
      for (int i = 0; i < q.size(); i++) if (q[i] !== e[i % 17]) bad++;
      checks++; if (!ok || q.size() % 17 != 0 || q.size() < 34 || bad != 0) begin errors++; $display("FAIL b2b_frames: got len=%0d bad=%0d want multiple of 17 bad=0", q.size(), bad); end
   endtask

   task automatic test_small();
      bq_t e;
      bit  ok = 1'b0;
      int  bad = 0;
      randomize_data();
      frame_cnt = 16'($urandom);
      mask2 = 4'hF;
      load_bus();
      q2.delete();
      e = model(4, 2, 1'b0, frame_cnt, 32'hF, wv, pv);
      pulse_start(1'b1);
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (!busy2) begin
            ok = 1'b1;
            break;
         end
      end
      checks++; if (!ok || q2.size() != 27) begin errors++; $display("FAIL small_len: got %0d want 27", q2.size()); end
      checks++; if (q2[7] !== 8'h00 || q2[12] !== 8'h01 || q2[8] !== wv[0][7:0] || q2[9] !== wv[0][15:8]) begin errors++; $display("FAIL small_fields: got %h %h %h %h want 00 01 %h %h", q2[7], q2[12], q2[8], q2[9], wv[0][7:0], wv[0][15:8]); end
      for (int i = 0; i < e.size(); i++) if (q2[i] !== e[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL small_bytes: got %0d mismatching bytes want 0", bad); end
   endtask

   task automatic test_reset_mid();
      bq_t e;
      bit  ok;
      int  bad = 0;
      randomize_data();
      frame_cnt = 16'($urandom);
      ch_mask = 12'hFFF;
      load_bus();
      q.delete();
      pulse_start(1'b0);
      for (int i = 0; i < 200 && q.size() < 50; i++) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      checks++; if (tx_fifo_wen !== 1'b0 || busy !== 1'b0 || overrun_cnt !== 8'h00) begin errors++; $display("FAIL rstmid_out: got wen=%b busy=%b ocnt=%h want 0 0 00", tx_fifo_wen, busy, overrun_cnt); end
      repeat (5) @(negedge clk);
      checks++; if (q.size() != 50) begin errors++; $display("FAIL rstmid_stop: got %0d bytes want 50", q.size()); end
      @(posedge clk);
      #1 rst = 1'b1;
      randomize_data();
      frame_cnt = 16'($urandom);
      ch_mask = 12'($urandom);
      load_bus();
      q.delete();
      e = model(12, 4, 1'b1, frame_cnt, {20'h0, ch_mask}, wv, pv);
      pulse_start(1'b0);
      wait_done(ok);
      checks++; if (q[0] !== 8'hFF || q[1] !== 8'h7F) begin errors++; $display("FAIL rstmid_hdr: got %h %h want FF 7F", q[0], q[1]); end
      for (int i = 0; i < e.size(); i++) if (q[i] !== e[i]) bad++;
      checks++; if (!ok || q.size() != e.size() || bad != 0) begin errors++; $display("FAIL rstmid_frame: got len=%0d bad=%0d want len=%0d bad=0", q.size(), bad, e.size()); end
   endtask

   initial begin
      rst = 1'b0;
      ena = 1'b1;
      frame_start = 1'b0;
      fs2 = 1'b0;
      frame_cnt = 16'h0;
      ch_mask = 12'h0;
      mask2 = 4'h0;
      width_bus = '0;
      period_bus = '0;
      wb2 = '0;
      pb2 = '0;
      tx_fifo_usedw = 12'd0;
      usedw2 = 12'd0;
      test_reset();
      test_all_channels();
      test_mask_and_ena();
      test_stall();
      test_overrun();
      test_small();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
